// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory with a fixed read latency
// between the instruction-fetch requester (I) and the load/store requester (D).
// At most one transaction is in flight; responses come back as per-requester
// one-cycle valid pulses.
//
// Optional build macro: ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, D above I
//   defined   : on a simultaneous request the requester not granted last wins
//
// Ports:
//   clk, res                          clock (rising edge), async active-high reset
//   if_req/if_addr -> if_gnt          instruction read request and its grant
//   if_rvalid/if_rdata                instruction response pulse and word
//   d_req/d_wr/d_size/d_addr/d_wdata  data request fields
//   d_gnt                             data grant
//   d_rvalid/d_rdata                  data response pulse (rdata = 0 on writes)
//   mem_req/mem_wr/mem_size/mem_addr/mem_wdata   one-cycle memory access strobe
//   mem_rdata                         memory read data
//   busy                              a transaction is in progress
// Timing: grant in cycle N, mem_req in N+1, rvalid in N+1+MEM_LATENCY, next
// grant no earlier than N+2+MEM_LATENCY. mem_rdata is sampled at the
// MEM_LATENCY-th rising edge after the edge that launches mem_req.

module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [1:0]            d_size,
    input  logic [31:0]           d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [1:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  busy
);

    localparam int unsigned      CNT_W     = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MEM_LATENCY - 1);
    localparam bit               LAT_ONE   = (MEM_LATENCY == 1);
    localparam logic [1:0]       SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             owner_d;   // 1 = D owns the transaction, 0 = I
    logic             cap_wr;    // transaction is a write: respond with 0
    logic             resp_fire; // sample mem_rdata at this edge

`ifdef ARB_ROUND_ROBIN_EN
    logic             last_d;    // last grant went to D
`endif

    // Upper requester address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_WIDTH], d_addr[31:ADDR_WIDTH]};

    // Grant decode: only in IDLE and never while reset is applied.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!res && state == ST_IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (d_req && if_req) begin
                d_gnt  = !last_d;
                if_gnt = last_d;
            end else begin
                d_gnt  = d_req;
                if_gnt = if_req;
            end
`else
            d_gnt  = d_req;
            if_gnt = if_req && !d_req;
`endif
        end
    end

    // The sampling edge is the one that makes the counter reach 0, so the
    // response pulse lands in the last busy cycle.
    assign resp_fire = (state == ST_ISSUE && LAT_ONE) ||
                       (state == ST_WAIT && cnt == CNT_W'(1));

    // Transaction FSM with registered memory-side outputs.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            owner_d   <= 1'b0;
            cap_wr    <= 1'b0;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_size  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d    <= 1'b0;
`endif
        end else begin
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_size  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (d_gnt) begin
                        state     <= ST_ISSUE;
                        busy      <= 1'b1;
                        owner_d   <= 1'b1;
                        cap_wr    <= d_wr;
                        mem_req   <= 1'b1;
                        mem_wr    <= d_wr;
                        mem_size  <= d_size;
                        mem_addr  <= d_addr[ADDR_WIDTH-1:0];
                        mem_wdata <= d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d    <= 1'b1;
`endif
                    end else if (if_gnt) begin
                        state     <= ST_ISSUE;
                        busy      <= 1'b1;
                        owner_d   <= 1'b0;
                        cap_wr    <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_size  <= SIZE_WORD;
                        mem_addr  <= if_addr[ADDR_WIDTH-1:0];
`ifdef ARB_ROUND_ROBIN_EN
                        last_d    <= 1'b0;
`endif
                    end
                end
                ST_ISSUE: begin
                    cnt   <= CNT_LOAD;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Response pulses; rdata holds its value between pulses.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if (resp_fire) begin
                if (owner_d) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= cap_wr ? 32'd0 : mem_rdata;
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LATENCY 1 and 3) with a
// behavioural memory each, a transaction-level reference model checked every
// cycle, and directed scenarios with hand-computed literal expectations.
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk;
    logic        res       [2];
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic        if_gnt    [2];
    logic        if_rvalid [2];
    logic [31:0] if_rdata  [2];
    logic        d_req     [2];
    logic        d_wr      [2];
    logic [1:0]  d_size    [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic        d_gnt     [2];
    logic        d_rvalid  [2];
    logic [31:0] d_rdata   [2];
    logic        mem_req   [2];
    logic        mem_wr    [2];
    logic [1:0]  mem_size  [2];
    logic [15:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit run    = 1'b0;

    mem_port_arbiter #(.ADDR_WIDTH(16), .MEM_LATENCY(1)) u_lat1 (
        .clk(clk), .res(res[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req[0]), .d_wr(d_wr[0]), .d_size(d_size[0]), .d_addr(d_addr[0]),
        .d_wdata(d_wdata[0]), .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .mem_req(mem_req[0]), .mem_wr(mem_wr[0]), .mem_size(mem_size[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .busy(busy[0])
    );

    mem_port_arbiter #(.ADDR_WIDTH(16), .MEM_LATENCY(3)) u_lat3 (
        .clk(clk), .res(res[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req[1]), .d_wr(d_wr[1]), .d_size(d_size[1]), .d_addr(d_addr[1]),
        .d_wdata(d_wdata[1]), .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .mem_req(mem_req[1]), .mem_wr(mem_wr[1]), .mem_size(mem_size[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int key(input int k, input logic [15:0] a);
        return k * 65536 + int'(32'(a));
    endfunction

    function automatic void chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cyc=%0d got=%h exp=%h", nm, k, cyc, got, exp);
        end
    endfunction

    // ---------------- behavioural memories (environment) ----------------
    logic [31:0] mstore [int];
    int          age    [2];
    logic [15:0] laddr  [2];

    function automatic logic [31:0] mem_rd(input int k, input logic [15:0] a);
        if (mstore.exists(key(k, a))) return mstore[key(k, a)];
        return {16'h5A00, a};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_req[k]) begin
                age[k]   <= 1;
                laddr[k] <= mem_addr[k];
                if (mem_wr[k]) mstore[key(k, mem_addr[k])] = mem_wdata[k];
            end else if (age[k] != 0 && age[k] < 100) begin
                age[k] <= age[k] + 1;
            end
        end
    end

    // Data is only valid in the cycle ending at the MEM_LATENCY-th edge.
    always begin
        @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            if (lat(k) == 1)
                mem_rdata[k] = mem_req[k] ? mem_rd(k, mem_addr[k]) : 32'hBAD0_0000;
            else
                mem_rdata[k] = (age[k] == lat(k) - 1) ? mem_rd(k, laddr[k]) : 32'hBAD0_0000;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [int];
    bit          m_act    [2];
    int          m_g      [2];
    bit          m_own_d  [2];
    bit          m_last_d [2];
    logic        m_wr     [2];
    logic [1:0]  m_sz     [2];
    logic [15:0] m_addr   [2];
    logic [31:0] m_wd     [2];
    logic [31:0] m_ird    [2];
    logic [31:0] m_drd    [2];

    function automatic logic [31:0] ref_rd(input int k, input logic [15:0] a);
        if (ref_mem.exists(key(k, a))) return ref_mem[key(k, a)];
        return {16'h5A00, a};
    endfunction

    always @(negedge clk) begin
        bit          eg_i, eg_d, e_mreq, e_irv, e_drv, e_busy, pick_d, e_mwr;
        logic [1:0]  e_msz;
        logic [15:0] e_maddr;
        logic [31:0] e_mwd;
        if (run) begin
            for (int k = 0; k < 2; k++) begin
                eg_i = 0; eg_d = 0; e_mreq = 0; e_irv = 0; e_drv = 0; e_busy = 0;
                e_mwr = 0; e_msz = 0; e_maddr = 0; e_mwd = 0; pick_d = 0;
                if (res[k]) begin
                    m_act[k] = 0; m_ird[k] = 0; m_drd[k] = 0; m_last_d[k] = 0;
                end else begin
                    if (m_act[k] && cyc > m_g[k] + 1 + lat(k)) m_act[k] = 0;
                    if (!m_act[k] && (d_req[k] || if_req[k])) begin
                        if (d_req[k] && if_req[k]) pick_d = RR_EN ? !m_last_d[k] : 1'b1;
                        else pick_d = d_req[k];
                        m_act[k] = 1; m_g[k] = cyc; m_own_d[k] = pick_d; m_last_d[k] = pick_d;
                        if (pick_d) begin
                            eg_d = 1; m_wr[k] = d_wr[k]; m_sz[k] = d_size[k];
                            m_addr[k] = d_addr[k][15:0]; m_wd[k] = d_wdata[k];
                        end else begin
                            eg_i = 1; m_wr[k] = 0; m_sz[k] = 2'd2;
                            m_addr[k] = if_addr[k][15:0]; m_wd[k] = 0;
                        end
                    end
                    if (m_act[k] && cyc == m_g[k] + 1) begin
                        e_mreq = 1; e_mwr = m_wr[k]; e_msz = m_sz[k];
                        e_maddr = m_addr[k]; e_mwd = m_wd[k];
                        if (m_wr[k]) ref_mem[key(k, m_addr[k])] = m_wd[k];
                    end
                    if (m_act[k] && cyc == m_g[k] + 1 + lat(k)) begin
                        if (m_own_d[k]) begin
                            e_drv = 1; m_drd[k] = m_wr[k] ? 32'd0 : ref_rd(k, m_addr[k]);
                        end else begin
                            e_irv = 1; m_ird[k] = ref_rd(k, m_addr[k]);
                        end
                    end
                    e_busy = m_act[k] && cyc > m_g[k];
                end
                chk("if_gnt",    k, 32'(if_gnt[k]),    32'(eg_i));
                chk("d_gnt",     k, 32'(d_gnt[k]),     32'(eg_d));
                chk("mem_req",   k, 32'(mem_req[k]),   32'(e_mreq));
                chk("mem_wr",    k, 32'(mem_wr[k]),    32'(e_mwr));
                chk("mem_size",  k, 32'(mem_size[k]),  32'(e_msz));
                chk("mem_addr",  k, 32'(mem_addr[k]),  32'(e_maddr));
                chk("mem_wdata", k, mem_wdata[k],      e_mwd);
                chk("if_rvalid", k, 32'(if_rvalid[k]), 32'(e_irv));
                chk("d_rvalid",  k, 32'(d_rvalid[k]),  32'(e_drv));
                chk("if_rdata",  k, if_rdata[k],       m_ird[k]);
                chk("d_rdata",   k, d_rdata[k],        m_drd[k]);
                chk("busy",      k, 32'(busy[k]),      32'(e_busy));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Raise one request, hold it until granted, drop it one edge later.
    task automatic req(input int k, input bit is_d, input bit wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, output int g);
        bit got;
        got = 0;
        g = -1;
        if (is_d) begin
            d_wr[k] = wr; d_size[k] = sz; d_addr[k] = a; d_wdata[k] = wd; d_req[k] = 1;
        end else begin
            if_addr[k] = a; if_req[k] = 1;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (is_d ? d_gnt[k] : if_gnt[k]) begin
                got = 1;
                g = cyc;
            end
        end
        chk("gnt_seen", k, 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (is_d) d_req[k] = 0;
        else if_req[k] = 0;
    endtask

    // Simultaneous I and D requests, each held until its own grant.
    task automatic pair(input int k, output bit first_d, output int gap);
        bit dg, ig;
        int gd, gi;
        dg = 0; ig = 0; gd = 0; gi = 0;
        d_wr[k] = 0; d_size[k] = 2'd2; d_addr[k] = 32'h0000_0200; d_wdata[k] = 32'h1111_2222;
        if_addr[k] = 32'h0000_0300;
        d_req[k] = 1; if_req[k] = 1;
        for (int i = 0; i < 40 && !(dg && ig); i++) begin
            @(negedge clk);
            if (d_gnt[k] && !dg) begin dg = 1; gd = cyc; end
            if (if_gnt[k] && !ig) begin ig = 1; gi = cyc; end
            @(posedge clk);
            #1;
            if (dg) d_req[k] = 0;
            if (ig) if_req[k] = 0;
        end
        chk("pair_both_granted", k, 32'({dg, ig}), 32'd3);
        d_req[k] = 0; if_req[k] = 0;
        first_d = gd < gi;
        gap = first_d ? gi - gd : gd - gi;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int  g;
        bit  fd;
        int  gap;
        for (int k = 0; k < 2; k++) begin
            res[k] = 0; if_req[k] = 0; if_addr[k] = 0; d_req[k] = 0; d_wr[k] = 0;
            d_size[k] = 0; d_addr[k] = 0; d_wdata[k] = 0; mem_rdata[k] = 0; age[k] = 0;
            laddr[k] = 0; m_act[k] = 0; m_g[k] = 0; m_own_d[k] = 0; m_last_d[k] = 0;
            m_wr[k] = 0; m_sz[k] = 0; m_addr[k] = 0; m_wd[k] = 0; m_ird[k] = 0; m_drd[k] = 0;
        end
        mstore[key(0, 16'h0010)]  = 32'h0000_0013;
        ref_mem[key(0, 16'h0010)] = 32'h0000_0013;
        mstore[key(1, 16'h0040)]  = 32'h4040_0040;
        ref_mem[key(1, 16'h0040)] = 32'h4040_0040;
        run = 1;
        #1;
        res[0] = 1; res[1] = 1;
        idle(2);
        res[0] = 0; res[1] = 0;
        idle(1);

        // Instruction read, latency 1.
        req(0, 0, 0, 2'd0, 32'h0000_0010, 32'h0, g);
        @(negedge clk);
        chk("t1_mem_req", 0, 32'(mem_req[0]), 32'd1);
        chk("t1_mem_addr", 0, 32'(mem_addr[0]), 32'h0010);
        chk("t1_mem_size", 0, 32'(mem_size[0]), 32'd2);
        @(negedge clk);
        chk("t1_if_rvalid", 0, 32'(if_rvalid[0]), 32'd1);
        chk("t1_if_rdata", 0, if_rdata[0], 32'h0000_0013);
        idle(2);

        // Byte write with address truncation.
        req(0, 1, 1, 2'd0, 32'h0001_2345, 32'h0000_00A5, g);
        @(negedge clk);
        chk("t2_mem_addr", 0, 32'(mem_addr[0]), 32'h2345);
        chk("t2_mem_wr", 0, 32'(mem_wr[0]), 32'd1);
        chk("t2_mem_wdata", 0, mem_wdata[0], 32'h0000_00A5);
        @(negedge clk);
        chk("t2_d_rvalid", 0, 32'(d_rvalid[0]), 32'd1);
        chk("t2_d_rdata", 0, d_rdata[0], 32'd0);
        idle(2);

        // Size 3 passes through untouched.
        req(0, 1, 0, 2'd3, 32'h0000_0123, 32'h0, g);
        @(negedge clk);
        chk("t2b_mem_size", 0, 32'(mem_size[0]), 32'd3);
        idle(3);

        // Write then read back the same word.
        req(0, 1, 1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF, g);
        idle(3);
        req(0, 1, 0, 2'd2, 32'h0000_0100, 32'h0, g);
        @(negedge clk);
        @(negedge clk);
        chk("t3_d_rvalid", 0, 32'(d_rvalid[0]), 32'd1);
        chk("t3_d_rdata", 0, d_rdata[0], 32'hDEAD_BEEF);
        idle(2);

        // Simultaneous pairs; last grant before this was D.
        for (int p = 0; p < 2; p++) begin
            pair(0, fd, gap);
            chk("t4_first_is_d", 0, 32'(fd), RR_EN ? 32'd0 : 32'd1);
            chk("t4_grant_gap", 0, 32'(gap), 32'd3);
            idle(5);
        end

        // Latency 3 data read; held if_req must be ignored while busy.
        req(1, 1, 0, 2'd2, 32'h0000_0040, 32'h0, g);
        if_addr[1] = 32'h0000_0080;
        if_req[1] = 1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t5_no_gnt_busy", 1, 32'(if_gnt[1]), 32'd0);
            if (i == 1) chk("t5_mem_req", 1, 32'(mem_req[1]), 32'd1);
            if (i == 4) begin
                chk("t5_d_rvalid", 1, 32'(d_rvalid[1]), 32'd1);
                chk("t5_d_rdata", 1, d_rdata[1], 32'h4040_0040);
            end
        end
        @(negedge clk);
        chk("t5_if_gnt_after", 1, 32'(if_gnt[1]), 32'd1);
        @(posedge clk);
        #1;
        if_req[1] = 0;
        idle(7);

        // Reset in the middle of WAIT drops the response.
        req(1, 1, 0, 2'd2, 32'h0000_0044, 32'h0, g);
        idle(1);
        if_addr[1] = 32'h0000_0088;
        if_req[1] = 1;
        res[1] = 1;
        @(negedge clk);
        chk("t6_busy", 1, 32'(busy[1]), 32'd0);
        chk("t6_mem_req", 1, 32'(mem_req[1]), 32'd0);
        chk("t6_rvalids", 1, 32'({if_rvalid[1], d_rvalid[1]}), 32'd0);
        chk("t6_gnts", 1, 32'({if_gnt[1], d_gnt[1]}), 32'd0);
        @(posedge clk);
        #1;
        res[1] = 0;
        @(negedge clk);
        chk("t6_if_gnt_after_reset", 1, 32'(if_gnt[1]), 32'd1);
        @(posedge clk);
        #1;
        if_req[1] = 0;
        idle(4);
        chk("t6_if_rdata", 1, if_rdata[1], 32'h5A00_0088);
        idle(3);

        run = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
